// File: rtl/fighter_physics_if.sv
// Signal bundle between a fighter's controller/arena logic and its physics block.
// The master drives the per-frame controls; the slave reports sprite position and motion state.
interface fighter_physics_if #(
    parameter int COORD_W = 8
);
    logic               tick;
    logic               player_no;
    logic               move_left;
    logic               move_right;
    logic               jump;
    logic               blocked_left;
    logic               blocked_right;
    logic               hit;
    logic               hit_dir;
    logic [COORD_W-1:0] sprite_x_out;
    logic [COORD_W-1:0] sprite_y_out;
    logic [1:0]         v_state;
    logic               airborne;
    logic               knockback;

    modport master (
        output tick, player_no, move_left, move_right, jump,
               blocked_left, blocked_right, hit, hit_dir,
        input  sprite_x_out, sprite_y_out, v_state, airborne, knockback
    );

    modport slave (
        input  tick, player_no, move_left, move_right, jump,
               blocked_left, blocked_right, hit, hit_dir,
        output sprite_x_out, sprite_y_out, v_state, airborne, knockback
    );
endinterface

// File: rtl/fighter_physics.sv
// Per-frame fighter motion: walking, knockback, and a jump/fall arc under gravity.
// Position advances only on tick; a hit arriving between ticks is held until the next tick.
module fighter_physics #(
    parameter int COORD_W     = 8,
    parameter int VEL_W       = 4,
    parameter int X_MIN       = 15,
    parameter int X_MAX       = 75,
    parameter int FLOOR_Y     = 48,
    parameter int CEIL_Y      = 0,
    parameter int WALK_STEP   = 1,
    parameter int JUMP_VEL    = 6,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 8,
    parameter int KNOCK_STEP  = 2,
    parameter int KNOCK_TICKS = 4
) (
    input logic              clk,
    input logic              reset,
    fighter_physics_if.slave bus
);
    localparam int XW = COORD_W + 2;
    localparam int KW = $clog2(KNOCK_TICKS + 1);

    typedef logic signed [XW-1:0] wide_t;
    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2, ILLEGAL = 2'd3} v_state_t;

    localparam wide_t ZERO_W   = wide_t'(0);
    localparam wide_t X_MIN_W  = wide_t'(X_MIN);
    localparam wide_t X_MAX_W  = wide_t'(X_MAX);
    localparam wide_t FLOOR_W  = wide_t'(FLOOR_Y);
    localparam wide_t CEIL_W   = wide_t'(CEIL_Y);
    localparam wide_t WALK_W   = wide_t'(WALK_STEP);
    localparam wide_t KNOCK_W  = wide_t'(KNOCK_STEP);
    localparam wide_t GRAV_W   = wide_t'(GRAVITY);
    localparam wide_t MAXF_W   = wide_t'(MAX_FALL);

    logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
    logic [VEL_W-1:0]   vy_q, vy_d;
    v_state_t           state_q, state_d;
    logic [KW-1:0]      knock_cnt_q, knock_cnt_d;
    logic               knock_dir_q, knock_dir_d;
    logic               hit_pending_q, pend_dir_q;

    logic  hit_now, knock_active;
    wide_t dx, x_sum, y_w, vy_w, y_t, vy_t;

    // NOTE: combinational logic uses blocking assignments, and every signal it
    // writes gets a default at the top so no latch is inferred.
    always_comb begin
        hit_now     = bus.hit | hit_pending_q;
        knock_cnt_d = knock_cnt_q;
        knock_dir_d = knock_dir_q;
        if (hit_now) begin
            knock_cnt_d = KW'(KNOCK_TICKS);
            knock_dir_d = bus.hit ? bus.hit_dir : pend_dir_q;
        end
        knock_active = (knock_cnt_d != '0);

        // Knockback overrides the walk controls but still respects collisions.
        dx = ZERO_W;
        if (knock_active) begin
            dx          = knock_dir_d ? KNOCK_W : -KNOCK_W;
            knock_cnt_d = knock_cnt_d - KW'(1);
        end else if (bus.move_right && !bus.move_left) begin
            dx = WALK_W;
        end else if (bus.move_left && !bus.move_right) begin
            dx = -WALK_W;
        end
        if ((dx > ZERO_W && bus.blocked_right) || (dx < ZERO_W && bus.blocked_left))
            dx = ZERO_W;

        x_sum = wide_t'({2'b00, x_q}) + dx;
        if (x_sum < X_MIN_W)      x_d = X_MIN_W[COORD_W-1:0];
        else if (x_sum > X_MAX_W) x_d = X_MAX_W[COORD_W-1:0];
        else                      x_d = x_sum[COORD_W-1:0];

        y_w     = wide_t'({2'b00, y_q});
        vy_w    = wide_t'({{(XW-VEL_W){1'b0}}, vy_q});
        y_t     = y_w;
        vy_t    = vy_w;
        state_d = state_q;
        y_d     = y_q;
        vy_d    = vy_q;
        case (state_q)
            GROUND: begin
                y_d = FLOOR_W[COORD_W-1:0];
                if (bus.jump && !knock_active) begin
                    state_d = RISE;
                    vy_d    = VEL_W'(JUMP_VEL);
                end
            end
            RISE: begin
                y_t  = y_w - vy_w;
                if (y_t < CEIL_W) y_t = CEIL_W;
                vy_t = (vy_w > GRAV_W) ? vy_w - GRAV_W : ZERO_W;
                y_d  = y_t[COORD_W-1:0];
                vy_d = vy_t[VEL_W-1:0];
                if (vy_t == ZERO_W || y_t == CEIL_W) begin
                    state_d = FALL;
                    vy_d    = '0;
                end
            end
            FALL: begin
                vy_t = vy_w + GRAV_W;
                if (vy_t > MAXF_W) vy_t = MAXF_W;
                y_t  = y_w + vy_t;
                if (y_t > FLOOR_W) y_t = FLOOR_W;
                y_d  = y_t[COORD_W-1:0];
                vy_d = vy_t[VEL_W-1:0];
                if (y_t == FLOOR_W) begin
                    state_d = GROUND;
                    vy_d    = '0;
                end
            end
            default: state_d = FALL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q           <= bus.player_no ? X_MAX_W[COORD_W-1:0] : X_MIN_W[COORD_W-1:0];
            y_q           <= FLOOR_W[COORD_W-1:0];
            vy_q          <= '0;
            state_q       <= GROUND;
            knock_cnt_q   <= '0;
            knock_dir_q   <= 1'b0;
            hit_pending_q <= 1'b0;
            pend_dir_q    <= 1'b0;
        end else if (bus.tick) begin
            x_q           <= x_d;
            y_q           <= y_d;
            vy_q          <= vy_d;
            state_q       <= state_d;
            knock_cnt_q   <= knock_cnt_d;
            knock_dir_q   <= knock_dir_d;
            hit_pending_q <= 1'b0;
        end else if (bus.hit) begin
            hit_pending_q <= 1'b1;
            pend_dir_q    <= bus.hit_dir;
        end
    end

    assign bus.sprite_x_out = x_q;
    assign bus.sprite_y_out = y_q;
    assign bus.v_state      = state_q;
    assign bus.airborne     = (state_q != GROUND);
    assign bus.knockback    = (knock_cnt_q != '0);
endmodule
